// File: rtl/mul8bit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul8bit_seq_pkg
// Description : Shared ULA definitions for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul8bit_seq_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply slot in the ULA operation mux, next to the divider
    localparam logic [3:0] c_op_mul = 4'd6;

endpackage
`default_nettype wire

// File: rtl/mul8bit_seq_mul_step.sv
`default_nettype none
// ============================================================================
// Module      : mul8bit_seq_mul_step
// Description : One combinational shift-add iteration of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mul8bit_seq_mul_step #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_bit,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic [2*WIDTH-1:0] o_acc_next
);

    logic [2*WIDTH-1:0] w_mcand_ext;
    logic [2*WIDTH-1:0] w_partial;

    assign w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};
    assign w_partial   = w_mcand_ext << i_cnt;
    // The full product of two WIDTH-bit values fits in 2*WIDTH bits, so no carry is lost
    assign o_acc_next  = i_bit ? (i_acc + w_partial) : i_acc;

endmodule
`default_nettype wire

// File: rtl/mul8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul8bit_seq
// Description : Sequential unsigned shift-add multiplier, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module mul8bit_seq
    import mul8bit_seq_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Product,
    output logic [WIDTH-1:0]   Result,
    output logic               Overflow,
    output logic               Zero
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_last;

    assign w_last = (r_cnt == c_last_cnt);

    mul8bit_seq_mul_step #(
        .WIDTH (WIDTH),
        .CNT_W (c_cnt_w)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .i_bit      (r_mplier[0]),
        .i_cnt      (r_cnt),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= A;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_cnt_one;
                    // Publish the accumulator including the final iteration
                    if (w_last) begin
                        r_product <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign Product  = r_product;
    assign Result   = r_product[WIDTH-1:0];
    assign Overflow = |r_product[2*WIDTH-1:WIDTH];
    assign Zero     = (r_product == '0);

endmodule
`default_nettype wire

// File: tb/tb_mul8bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul8bit_seq
// Description : Self-checking bench for mul8bit_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul8bit_seq;

    localparam int c_lat = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] Product;
    logic [7:0]  Result;
    logic        Overflow;
    logic        Zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    mul8bit_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Product  (Product),
        .Result   (Result),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [15:0] ref_mul(input int a, input int b);
        return 16'(a * b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy !== 1'b0; i++) step();
    endtask

    // Pulses start for one edge and returns the number of edges until done is seen
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        wait_idle();
        A = a; B = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done got %b expected 00", {busy, done});
        end
        checks++;
        if ({Product, Result, Overflow, Zero} !== {16'd0, 8'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_data: P=%0d R=%0d O=%b Z=%b expected P=0 R=0 O=0 Z=1",
                     Product, Result, Overflow, Zero);
        end
    endtask

    task automatic test_basic();
        int lat;
        do_op(8'd13, 8'd11, lat);
        checks++;
        if (lat !== c_lat) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, c_lat);
        end
        checks++;
        if ({Product, Result, Overflow, Zero} !== {16'd143, 8'd143, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_value: P=%0d R=%0d O=%b Z=%b expected P=143 R=143 O=0 Z=0",
                     Product, Result, Overflow, Zero);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL basic_strobe: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_max();
        int lat;
        do_op(8'd255, 8'd255, lat);
        checks++;
        if (lat !== c_lat || {Product, Result, Overflow, Zero} !== {16'hFE01, 8'h01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL max_value: lat=%0d P=%h R=%h O=%b Z=%b expected lat=8 P=fe01 R=01 O=1 Z=0",
                     lat, Product, Result, Overflow, Zero);
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [7:0] za [2] = '{8'd0, 8'd37};
        logic [7:0] zb [2] = '{8'd200, 8'd0};
        for (int i = 0; i < 2; i++) begin
            do_op(za[i], zb[i], lat);
            checks++;
            if (lat !== c_lat || {Product, Overflow, Zero} !== {16'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL zero_operand%0d: lat=%0d P=%0d O=%b Z=%b expected lat=8 P=0 O=0 Z=1",
                         i, lat, Product, Overflow, Zero);
            end
        end
    endtask

    task automatic test_ignore_start();
        int d0;
        int seen;
        wait_idle();
        d0 = done_cnt;
        A = 8'd16; B = 8'd16; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        A = 8'd3; B = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            step();
        end
        checks++;
        if (seen != 1 || {Product, Result, Overflow} !== {16'd256, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL ignore_value: seen=%0d P=%0d R=%0d O=%b expected seen=1 P=256 R=0 O=1",
                     seen, Product, Result, Overflow);
        end
        for (int n = 0; n < 15; n++) step();
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_pulses: done pulses=%0d busy=%b expected 1 and 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int lat;
        wait_idle();
        A = 8'd20; B = 8'd20; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 5; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        d0 = done_cnt;
        checks++;
        if ({busy, done, Product, Zero} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_state: busy=%b done=%b P=%0d Z=%b expected 0 0 0 1",
                     busy, done, Product, Zero);
        end
        for (int n = 0; n < 15; n++) step();
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL midreset_nodone: done pulses=%0d expected 0", done_cnt - d0);
        end
        do_op(8'd7, 8'd6, lat);
        checks++;
        if (lat !== c_lat || Product !== 16'd42) begin
            failures++;
            $display("FAIL midreset_after: lat=%0d P=%0d expected lat=8 P=42", lat, Product);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        wait_idle();
        t1 = -1; t2 = -1;
        A = 8'd12; B = 8'd12; start = 1'b1;
        step();
        A = 8'd200; B = 8'd2;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done === 1'b1) begin
                t1 = cyc;
                break;
            end
        end
        checks++;
        if (t1 < 0 || Product !== 16'd144) begin
            failures++;
            $display("FAIL b2b_first: seen=%0d P=%0d expected seen=1 P=144", (t1 >= 0), Product);
        end
        for (int n = 0; n < 20; n++) begin
            step();
            if (done === 1'b1) begin
                t2 = cyc;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (t2 < 0 || {Product, Result, Overflow} !== {16'd400, 8'd144, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second: seen=%0d P=%0d R=%0d O=%b expected seen=1 P=400 R=144 O=1",
                     (t2 >= 0), Product, Result, Overflow);
        end
        checks++;
        if (t2 - t1 != 10) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected 10", t2 - t1);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        logic [15:0] prev;
        wait_idle();
        prev = Product;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            checks++;
            if (Product !== prev) begin
                failures++;
                $display("FAIL rand_hold%0d: P=%0d expected %0d", i, Product, prev);
            end
            do_op(a, b, lat);
            exp = ref_mul(int'(a), int'(b));
            checks++;
            if (lat !== c_lat || Product !== exp || Result !== exp[7:0] ||
                Overflow !== (exp[15:8] != 8'd0) || Zero !== (exp == 16'd0)) begin
                failures++;
                $display("FAIL rand_op%0d: %0d*%0d lat=%0d P=%0d R=%0d O=%b Z=%b expected lat=8 P=%0d",
                         i, a, b, lat, Product, Result, Overflow, Zero, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
